// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the CPU/DMA block-RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned DEF_RAM_ADDR_BITS = 15;
    localparam int unsigned CPU_ADDR_W        = 16;
    localparam int unsigned DATA_W            = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter.sv
// Shares one block-RAM port between the CPU (absolute priority on its
// pre/clken slots) and a single DMA requester that uses the free cycles.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter int unsigned RAM_END       = 32'(1) << RAM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_pre,
    input  logic                     cpu_clken,
    input  logic [CPU_ADDR_W-1:0]    cpu_addr,
    input  logic                     cpu_we,
    input  logic [DATA_W-1:0]        cpu_dout,
    input  logic                     dma_req,
    input  logic                     dma_we,
    input  logic [RAM_ADDR_BITS-1:0] dma_addr,
    input  logic [DATA_W-1:0]        dma_wdata,
    output logic                     dma_ack,
    output logic [DATA_W-1:0]        dma_rdata,
    output logic                     dma_busy,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic                     ram_we,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata
);

    arb_state_e          state_q;
    logic                dma_ack_q;
    logic [DATA_W-1:0]   dma_rdata_q;

    logic cpu_ram_sel_c;
    logic cpu_slot_c;
    logic grant_c;

    // CPU owns the port only when its slot actually targets RAM
    assign cpu_ram_sel_c = (32'(cpu_addr) < RAM_END);
    assign cpu_slot_c    = (cpu_pre | cpu_clken) & cpu_ram_sel_c;
    assign grant_c       = (state_q == IDLE) & dma_req & ~cpu_slot_c & ~reset;

    // RAM port mux; address defaults to the CPU so its reads are never delayed
    always_comb begin
        ram_addr  = cpu_addr[RAM_ADDR_BITS-1:0];
        ram_wdata = cpu_dout;
        ram_we    = cpu_slot_c & cpu_clken & cpu_we;
        if (grant_c) begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
            ram_we    = dma_we;
        end
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // Grant -> capture registered RAM data -> one-cycle ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= '0;
        end else begin
            dma_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    dma_rdata_q <= ram_rdata;
                    dma_ack_q   <= 1'b1;
                    state_q     <= ACK;
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dma_ack   = dma_ack_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_busy  = grant_c | (state_q != IDLE);

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter RAM_ADDR_BITS, default 15, the block RAM address width (32K).
REQ-002 SHALL have parameter RAM_END, default 2**RAM_ADDR_BITS, the first CPU address outside RAM.
REQ-003 clk  in  1  system clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_pre  in  1  high the cycle before cpu_clken (CPU read-address cycle).
REQ-006 cpu_clken  in  1  CPU clock enable (CPU write/sample cycle).
REQ-007 cpu_addr  in  16  registered CPU address, stable across cpu_pre and cpu_clken.
REQ-008 cpu_we  in  1  registered CPU write enable.
REQ-009 cpu_dout  in  8  registered CPU write data.
REQ-010 dma_req  in  1  DMA request; held with dma_addr, dma_we and dma_wdata stable until dma_ack.
REQ-011 dma_we  in  1  1 = write, 0 = read.
REQ-012 dma_addr  in  RAM_ADDR_BITS  DMA RAM address.
REQ-013 dma_wdata  in  8  DMA write data.
REQ-014 dma_ack  out  1  one-cycle completion pulse, registered.
REQ-015 dma_rdata  out  8  read data, valid while dma_ack is high, registered.
REQ-016 dma_busy  out  1  high from grant through the ack cycle.
REQ-017 ram_addr  out  RAM_ADDR_BITS  block RAM address, combinational.
REQ-018 ram_we  out  1  block RAM write strobe, combinational.
REQ-019 ram_wdata  out  8  block RAM write data, combinational.
REQ-020 ram_rdata  in  8  block RAM registered read data (one-cycle latency); also routed unchanged to the CPU data mux outside this block.

Function
REQ-021 cpu_ram_sel SHALL be (cpu_addr < RAM_END); cpu_slot SHALL be (cpu_pre | cpu_clken) & cpu_ram_sel.
REQ-022 The CPU SHALL have absolute priority: in a cpu_slot cycle, ram_addr = cpu_addr[RAM_ADDR_BITS-1:0], ram_wdata = cpu_dout, ram_we = cpu_clken & cpu_we.
REQ-023 In a cycle where cpu_slot is low and no grant is issued, ram_addr SHALL hold cpu_addr[RAM_ADDR_BITS-1:0] and ram_we SHALL be 0.
REQ-024 Grant in cycle G SHALL require state IDLE, dma_req=1, cpu_slot=0 and reset=0; in G, ram_addr = dma_addr, ram_wdata = dma_wdata, ram_we = dma_we.
REQ-025 Because cpu_slot includes cpu_ram_sel, DMA SHALL also be granted during cpu_pre/cpu_clken cycles in which the CPU address is outside RAM.
REQ-026 States: IDLE -> (grant) CAPT -> ACK -> IDLE; CAPT and ACK SHALL last exactly one cycle each.
REQ-027 In CAPT (G+1), dma_rdata SHALL load ram_rdata on the clock edge ending CAPT, and dma_ack SHALL be set on the same edge.
REQ-028 dma_ack SHALL be high for exactly cycle G+2 (ACK state), for both reads and writes; in ACK, dma_rdata holds the read data and dma_req SHALL be ignored.
REQ-029 Earliest next grant SHALL be G+3; back-to-back throughput SHALL be one access per 3 cycles with no CPU contention.
REQ-030 If dma_req is high while cpu_slot is high, the arbiter SHALL wait in IDLE with no side effects until a free cycle.
REQ-031 dma_rdata after a write ack SHALL be unspecified; dma_rdata SHALL hold its value outside ack cycles.
REQ-032 dma_busy SHALL be high in G (combinational grant), CAPT and ACK.

Reset
REQ-033 While reset is high, ram_we SHALL be 0 combinationally and no grant SHALL be issued.
REQ-034 On a clock edge with reset high, state SHALL become IDLE and dma_ack, dma_rdata and dma_busy SHALL become 0.
REQ-035 Reset in CAPT or ACK SHALL abandon the access with no ack; a write already strobed in G remains committed.

Structure
REQ-036 Package ram_arb_pkg SHALL hold the state enum (IDLE, CAPT, ACK) and the default RAM_ADDR_BITS constant.
REQ-037 The block SHALL be a single module with no sub-modules; the RAM array stays outside it.

Verification
REQ-038 CPU idle at 0xC000 (ROM), cpu_pre/cpu_clken pulsing 1-in-4: DMA write 0x0123 <= 0xA5 then read 0x0123 -> dma_rdata = 0xA5 with ack at G+2 each time.
REQ-039 CPU writes 0x55 to 0x0010 on every cpu_clken while DMA reads 0x0010 continuously -> no grant ever lands on a cpu_pre/cpu_clken cycle; DMA read returns 0x55.
REQ-040 dma_req held high for 12 cycles with a free bus -> exactly 4 acks, spaced 3 cycles apart.
REQ-041 Reset asserted in CAPT of a read -> no dma_ack; state IDLE; dma_rdata = 0x00 next cycle.
REQ-042 dma_req rises in a cpu_pre cycle with cpu_addr = 0x7FFF -> grant deferred 2 cycles to the first free cycle; ack 2 cycles after grant.
REQ-043 Boundary: cpu_addr = 0x8000 (ACIA) during cpu_clken with cpu_we=1 -> ram_we follows the DMA grant only; RAM contents at 0x0000 unchanged.
